id_ex_stage: RTL

Pipeline register between decode and execute in the five-stage core. Captures decoded instruction fields each cycle, resolves operand forwarding from the MEM and WB stages, and drives the ALU's `op`, `A`, `B` inputs plus the control that travels with the instruction into MEM. It also detects load-use hazards and inserts its own bubble. It handles stall and flush so the ALU always sees a valid instruction or a clean bubble.

---
 rtl/id_ex_stage_if.sv | 31 +++
 rtl/id_ex_stage.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/id_ex_stage_if.sv
// Decode-side bundle feeding the ID/EX pipeline register.
// The decoder drives through master; the pipeline register consumes through slave.
interface id_ex_stage_if;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [31:0] id_rs1_data;
   logic [31:0] id_rs2_data;
   logic [31:0] id_imm;
   logic [4:0]  id_rs1;
   logic [4:0]  id_rs2;
   logic [4:0]  id_rd;
   logic [3:0]  id_alu_op;
   logic        id_asel;
   logic        id_bsel;
   logic        id_wb_en;
   logic [1:0]  id_wb_sel;
   logic        id_mem_we;
   logic        id_branch;

   modport master (
      output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
             id_rs1, id_rs2, id_rd, id_alu_op, id_asel, id_bsel,
             id_wb_en, id_wb_sel, id_mem_we, id_branch
   );

   modport slave (
      input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
             id_rs1, id_rs2, id_rd, id_alu_op, id_asel, id_bsel,
             id_wb_en, id_wb_sel, id_mem_we, id_branch
   );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: operand forwarding from MEM/WB, load-use bubble
// insertion, and stall/flush handling so EX sees a real instruction or a clean bubble.
module id_ex_stage #(
   parameter logic [3:0] ALU_ADD = 4'd0,
   parameter logic [1:0] WB_LOAD = 2'b01
) (
   input  logic          cpu_clk,
   input  logic          cpu_rst,
   id_ex_stage_if.slave  id,
   input  logic          stall,
   input  logic          flush,
   input  logic          mem_wb_en,
   input  logic [4:0]    mem_rd,
   input  logic [31:0]   mem_data,
   input  logic          wb_wb_en,
   input  logic [4:0]    wb_rd,
   input  logic [31:0]   wb_data,
   output logic          ex_valid,
   output logic [3:0]    alu_op,
   output logic [31:0]   alu_a,
   output logic [31:0]   alu_b,
   output logic [31:0]   ex_pc,
   output logic [31:0]   ex_imm,
   output logic [31:0]   ex_store_data,
   output logic [4:0]    ex_rd,
   output logic          ex_wb_en,
   output logic [1:0]    ex_wb_sel,
   output logic          ex_mem_we,
   output logic          ex_branch,
   output logic          load_use
);

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] rs1_data;
      logic [31:0] rs2_data;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [3:0]  alu_op;
      logic        asel;
      logic        bsel;
      logic        wb_en;
      logic [1:0]  wb_sel;
      logic        mem_we;
      logic        branch;
   } ex_state_t;

   function automatic ex_state_t bubble();
      ex_state_t b;
      b        = '0;
      b.alu_op = ALU_ADD;
      return b;
   endfunction

   ex_state_t state_reg;
   ex_state_t state_next;

   // Index 0 is rs1, index 1 is rs2 for all per-operand arrays below.
   logic [4:0]  ex_src_addr [2];
   logic [31:0] ex_src_data [2];
   logic [4:0]  id_src_addr [2];
   logic [31:0] id_src_data [2];
   logic [31:0] fwd_data    [2];
   logic [31:0] cap_data    [2];

   assign ex_src_addr[0] = state_reg.rs1;
   assign ex_src_addr[1] = state_reg.rs2;
   assign ex_src_data[0] = state_reg.rs1_data;
   assign ex_src_data[1] = state_reg.rs2_data;
   assign id_src_addr[0] = id.id_rs1;
   assign id_src_addr[1] = id.id_rs2;
   assign id_src_data[0] = id.id_rs1_data;
   assign id_src_data[1] = id.id_rs2_data;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_operand
         logic mem_hit;
         logic wb_hit;
         logic wb_cap_hit;

         // x0 is hard-wired zero, so a write to it must never be forwarded.
         assign mem_hit    = mem_wb_en && (mem_rd != 5'd0) && (mem_rd == ex_src_addr[gi]);
         assign wb_hit     = wb_wb_en  && (wb_rd  != 5'd0) && (wb_rd  == ex_src_addr[gi]);
         assign wb_cap_hit = wb_wb_en  && (wb_rd  != 5'd0) && (wb_rd  == id_src_addr[gi]);

         assign fwd_data[gi] = mem_hit ? mem_data :
                               wb_hit  ? wb_data  : ex_src_data[gi];
         // Register file reads the old value in the write cycle; bypass it here.
         assign cap_data[gi] = wb_cap_hit ? wb_data : id_src_data[gi];
      end
   endgenerate

   assign load_use = !stall && !flush
                  && state_reg.valid && state_reg.wb_en
                  && (state_reg.wb_sel == WB_LOAD) && (state_reg.rd != 5'd0)
                  && id.id_valid
                  && ((state_reg.rd == id.id_rs1) || (state_reg.rd == id.id_rs2));

   always_comb begin
      state_next = state_reg;
      if (flush || load_use) begin
         state_next = bubble();
      end else if (stall) begin
         // Refresh held operands so producers retiring during the stall are kept.
         state_next.rs1_data = fwd_data[0];
         state_next.rs2_data = fwd_data[1];
      end else begin
         state_next.valid    = id.id_valid;
         state_next.pc       = id.id_pc;
         state_next.rs1_data = cap_data[0];
         state_next.rs2_data = cap_data[1];
         state_next.imm      = id.id_imm;
         state_next.rs1      = id.id_rs1;
         state_next.rs2      = id.id_rs2;
         state_next.rd       = id.id_rd;
         state_next.alu_op   = id.id_alu_op;
         state_next.asel     = id.id_asel;
         state_next.bsel     = id.id_bsel;
         state_next.wb_en    = id.id_wb_en;
         state_next.wb_sel   = id.id_wb_sel;
         state_next.mem_we   = id.id_mem_we;
         state_next.branch   = id.id_branch;
      end
   end

   always_ff @(posedge cpu_clk) begin
      if (cpu_rst) begin
         state_reg <= bubble();
      end else begin
         state_reg <= state_next;
      end
   end

   assign ex_valid      = state_reg.valid;
   assign alu_op        = state_reg.alu_op;
   assign alu_a         = state_reg.asel ? state_reg.pc  : fwd_data[0];
   assign alu_b         = state_reg.bsel ? state_reg.imm : fwd_data[1];
   assign ex_pc         = state_reg.pc;
   assign ex_imm        = state_reg.imm;
   assign ex_store_data = fwd_data[1];
   assign ex_rd         = state_reg.rd;
   assign ex_wb_en      = state_reg.wb_en;
   assign ex_wb_sel     = state_reg.wb_sel;
   assign ex_mem_we     = state_reg.mem_we;
   assign ex_branch     = state_reg.branch;

endmodule
